// File: rtl/multiword_serial_adder.sv
// multiword_serial_adder: adds two WIDTH-bit operands one byte per cycle,
// LSB first, through a single 8-bit carry-select adder core with a
// registered inter-chunk carry. Operands arrive and the result leaves over
// valid/ready handshakes.
// Optional: define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.

module carry_select_8b_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  // Low nibble ripples; high nibble is precomputed for both carries and selected.
  always_comb begin
    lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
    hi0  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    s    = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    cout = lo[4] ? hi1[4] : hi0[4];
  end
endmodule

module multiword_serial_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int unsigned NCHUNK = WIDTH / 8;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (((WIDTH % 8) != 0) || (WIDTH < 16)) begin : g_width_err
    $error("multiword_serial_adder: WIDTH must be a multiple of 8 and >= 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic [7:0] core_a;
  logic [7:0] core_b;
  logic [7:0] core_s;
  logic       core_cout;

  carry_select_8b_adder u_core (
    .a    (core_a),
    .b    (core_b),
    .cin  (carry_q),
    .s    (core_s),
    .cout (core_cout)
  );

  // Route the operand byte selected by the chunk counter into the core.
  always_comb begin
    core_a = '0;
    core_b = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        core_a = a_q[8*k +: 8];
        core_b = b_q[8*k +: 8];
      end
    end
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned k = 0; k < NCHUNK; k++) begin
          if (cnt_q == CW'(k)) begin
            sum_d[8*k +: 8] = core_s;
          end
        end
        carry_d = core_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Counter is parked at zero on exit so it never wraps past the top chunk.
          cnt_d   = '0;
          cout_d  = core_cout;
          state_d = S_DONE;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = (core_a[7] & core_b[7] & ~core_s[7]) |
                    (~core_a[7] & ~core_b[7] & core_s[7]);
`endif
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_serial_adder.sv
// Directed bench for multiword_serial_adder (WIDTH=32). Inputs change on the
// falling edge; outputs are sampled on the falling edge or 1 time unit after
// the rising edge.

module tb_multiword_serial_adder;
  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_chk;
  int n_bad;

  multiword_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present operands, wait for the accept, then wait for out_valid.
  task automatic start_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input bit chk_lat);
    int n;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    a = va;
    b = vb;
    cin = vc;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '1;
    b = '1;
    cin = 1'b1;
    if (chk_lat) begin
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd4);
    end
  endtask

  task automatic finish_op(input string tag, input logic [W-1:0] esum, input logic ecout);
    @(negedge clk);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(sum), 64'(esum));
    check({tag, "_cout"}, 64'(cout), 64'(ecout));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  logic [W-1:0] bva [3];
  logic [W-1:0] bvb [3];
  logic         bvc [3];
  logic [W-1:0] bes [3];
  logic         bec [3];
  int           acc [3];

  initial begin
    int ai;
    int ri;
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Full carry chain through every byte.
    start_op("ffff", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
    check("ffff_ovf", 64'(ovf), 64'd0);
`endif
    finish_op("ffff", 32'h0000_0000, 1'b1);

    start_op("mix", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1);
    finish_op("mix", 32'h2345_678A, 1'b0);

    start_op("alt", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b1);
    finish_op("alt", 32'h0100_0100, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
    start_op("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    check("ovf_ovf", 64'(ovf), 64'd1);
    finish_op("ovf", 32'h8000_0000, 1'b0);
`endif

    // Backpressure: result held while new operands wait.
    start_op("bp1", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'h8000_0000;
    b = 32'h8000_0000;
    cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_sum", 64'(sum), 64'h0000_0030);
      check("bp_hold_cout", 64'(cout), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_pending_taken", 64'(in_ready), 64'd0);
    begin
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("bp2_latency", 64'(lat), 64'd4);
    end
    finish_op("bp2", 32'h0000_0001, 1'b1);

    // Reset pulse two cycles into RUN.
    start_op("rstop", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_cout", 64'(cout), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    start_op("post_rst", 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b1);
    finish_op("post_rst", 32'h0000_0005, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    bva[0] = 32'h0000_00FF; bvb[0] = 32'h0000_0001; bvc[0] = 1'b0; bes[0] = 32'h0000_0100; bec[0] = 1'b0;
    bva[1] = 32'hFFFF_0000; bvb[1] = 32'h0001_0000; bvc[1] = 1'b0; bes[1] = 32'h0000_0000; bec[1] = 1'b1;
    bva[2] = 32'h0F0F_0F0F; bvb[2] = 32'hF0F0_F0F0; bvc[2] = 1'b1; bes[2] = 32'h0000_0000; bec[2] = 1'b1;
    ai = 0;
    ri = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && ri < 3; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        check("b2b_sum", 64'(sum), 64'(bes[ri]));
        check("b2b_cout", 64'(cout), 64'(bec[ri]));
        ri++;
      end
      if (in_ready) begin
        if (ai < 3) begin
          a = bva[ai];
          b = bvb[ai];
          cin = bvc[ai];
          in_valid = 1'b1;
          acc[ai] = cyc;
          ai++;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_results", 64'(ri), 64'd3);
    check("b2b_accepts", 64'(ai), 64'd3);
    check("b2b_gap01", 64'(acc[1] - acc[0]), 64'd6);
    check("b2b_gap12", 64'(acc[2] - acc[1]), 64'd6);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_idle", 64'(in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
